dcm_ps_responder: RTL and testbench



---
 rtl/dcm_ps_pkg.sv | 37 +++
 rtl/dcm_ps_responder.sv | 94 +++++++++
 tb/tb_dcm_ps_responder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcm_ps_pkg.sv
// Shared types and helpers for the DCM variable-phase-shift responder.
// Holds the FSM encoding, default sizing constants and the saturating offset step.
package dcm_ps_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } ps_state_t;

  localparam int PS_WIDTH_D   = 9;
  localparam int PS_MAX_D     = 255;
  localparam int PS_LATENCY_D = 4;
  localparam int PS_CALC_W    = 32;

  // Packed so a caller can cast the result down to {offset[W-1:0], ovf}.
  typedef struct packed {
    logic signed [PS_CALC_W-1:0] offset;
    logic                        ovf;
  } ps_step_t;

  // One increment/decrement of the phase offset, clamped to +/-max.
  function automatic ps_step_t ps_sat_step(input int offset, input logic dir, input int max);
    ps_step_t res;
    res.offset = offset;
    res.ovf    = 1'b0;
    if (dir) begin
      if (offset < max) res.offset = offset + 1;
      else              res.ovf    = 1'b1;
    end else begin
      if (offset > -max) res.offset = offset - 1;
      else               res.ovf    = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dcm_ps_responder.sv
// DCM-side emulation of the PSEN/PSINCDEC/PSDONE handshake with a saturating
// signed phase-offset register; lives in the clkin domain.
module dcm_ps_responder
  import dcm_ps_pkg::*;
#(
  parameter int PS_WIDTH   = PS_WIDTH_D,
  parameter int PS_MAX     = PS_MAX_D,
  parameter int PS_LATENCY = PS_LATENCY_D
) (
  input  logic                       clkin,
  input  logic                       rst,
  input  logic                       locked,
  input  logic                       psen,
  input  logic                       psincdec,
  output logic                       psdone,
  output logic signed [PS_WIDTH-1:0] phase_offset,
  output logic                       ps_overflow,
  output logic                       ps_busy,
  output logic                       proto_err
);

  ps_state_t                 r_state;
  ps_state_t                 w_state_nxt;
  logic [7:0]                r_cnt;
  logic                      r_dir;
  logic signed [PS_WIDTH-1:0] r_offset;
  logic                      r_ovf;
  logic                      r_proto_err;

  logic                      w_accept;
  logic                      w_dir;
  logic signed [PS_WIDTH-1:0] w_next_offset;
  logic                      w_next_ovf;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (psen && locked) begin
          w_accept    = 1'b1;
          w_state_nxt = (PS_LATENCY == 1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: if (r_cnt == 8'd1) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clkin) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // With PS_LATENCY=1 the direction is consumed on the accept edge itself.
  assign w_dir = w_accept ? psincdec : r_dir;

  always_comb begin
    {w_next_offset, w_next_ovf} = (PS_WIDTH + 1)'(ps_sat_step(int'(r_offset), w_dir, PS_MAX));
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_cnt       <= 8'd0;
      r_dir       <= 1'b0;
      r_offset    <= '0;
      r_ovf       <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= psen && locked && (r_state != ST_IDLE);
      if (w_accept) begin
        r_dir <= psincdec;
        r_cnt <= 8'(PS_LATENCY - 1);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 8'd1;
      end
      // Offset commits on the edge entering DONE so it is visible alongside psdone.
      if (w_state_nxt == ST_DONE) begin
        r_offset <= w_next_offset;
        r_ovf    <= w_next_ovf;
      end
    end
  end

  assign psdone       = (r_state == ST_DONE);
  assign ps_busy      = (r_state != ST_IDLE);
  assign phase_offset = r_offset;
  assign ps_overflow  = r_ovf;
  assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_dcm_ps_responder.sv
// Directed bench for dcm_ps_responder: a default instance and a PS_MAX=3 instance,
// with expected offsets queued at request time and popped on each psdone.
module tb_dcm_ps_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_locked = 1'b0, a_psen = 1'b0, a_incdec = 1'b0;
  logic a_psdone, a_ovf, a_busy, a_perr;
  logic signed [8:0] a_off;

  logic b_locked = 1'b0, b_psen = 1'b0, b_incdec = 1'b0;
  logic b_psdone, b_ovf, b_busy, b_perr;
  logic signed [8:0] b_off;

  dcm_ps_responder #(.PS_WIDTH(9), .PS_MAX(255), .PS_LATENCY(4)) u_dut (
    .clkin(clk), .rst(rst), .locked(a_locked), .psen(a_psen), .psincdec(a_incdec),
    .psdone(a_psdone), .phase_offset(a_off), .ps_overflow(a_ovf), .ps_busy(a_busy),
    .proto_err(a_perr)
  );

  dcm_ps_responder #(.PS_WIDTH(9), .PS_MAX(3), .PS_LATENCY(4)) u_sat (
    .clkin(clk), .rst(rst), .locked(b_locked), .psen(b_psen), .psincdec(b_incdec),
    .psdone(b_psdone), .phase_offset(b_off), .ps_overflow(b_ovf), .ps_busy(b_busy),
    .proto_err(b_perr)
  );

  typedef struct {
    int off;
    bit ovf;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   ma_off = 0, mb_off = 0;
  int   n_tests = 0, n_fail = 0;
  int   a_done_cnt = 0, a_perr_cnt = 0, b_done_cnt = 0, b_perr_cnt = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int model_step(input int off, input bit dir, input int max,
                                    output bit ovf);
    ovf = 1'b0;
    if (dir && off < max) return off + 1;
    if (!dir && off > -max) return off - 1;
    ovf = 1'b1;
    return off;
  endfunction

  task automatic push_a(input bit dir);
    bit o;
    ma_off = model_step(ma_off, dir, 255, o);
    sb_a.push_back('{ma_off, o});
  endtask

  task automatic push_b(input bit dir);
    bit o;
    mb_off = model_step(mb_off, dir, 3, o);
    sb_b.push_back('{mb_off, o});
  endtask

  // Advance one edge, then sample away from it and retire any completions.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (a_psdone === 1'b1) begin
      a_done_cnt++;
      check("a_sb_nonempty", int'(sb_a.size() != 0), 1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        check("a_offset", $signed(a_off), e.off);
        check("a_ovf", a_ovf, e.ovf);
      end
    end
    if (b_psdone === 1'b1) begin
      b_done_cnt++;
      check("b_sb_nonempty", int'(sb_b.size() != 0), 1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        check("b_offset", $signed(b_off), e.off);
        check("b_ovf", b_ovf, e.ovf);
      end
    end
    if (a_perr === 1'b1) a_perr_cnt++;
    if (b_perr === 1'b1) b_perr_cnt++;
  endtask

  task automatic req_a(input bit dir);
    int n;
    push_a(dir);
    a_psen   = 1'b1;
    a_incdec = dir;
    tick();
    a_psen = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("a_req_complete", int'(a_busy === 1'b0), 1);
  endtask

  task automatic req_b(input bit dir);
    int n;
    push_b(dir);
    b_psen   = 1'b1;
    b_incdec = dir;
    tick();
    b_psen = 1'b0;
    n = 0;
    while (b_busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("b_req_complete", int'(b_busy === 1'b0), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ma_off = 0;
    mb_off = 0;
    sb_a.delete();
    sb_b.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed stuck simulation expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, p0;

    // Reset values.
    do_reset();
    tick();
    check("rst_psdone", a_psdone, 0);
    check("rst_offset", $signed(a_off), 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_busy", a_busy, 0);
    check("rst_perr", a_perr, 0);

    // Single increment: busy T+1..T+4, psdone only in T+4.
    a_locked = 1'b1;
    b_locked = 1'b1;
    push_a(1'b1);
    a_psen   = 1'b1;
    a_incdec = 1'b1;
    tick();
    a_psen = 1'b0;
    check("t1_busy_c1", a_busy, 1);
    check("t1_done_c1", a_psdone, 0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("t1_busy", a_busy, 1);
      check("t1_done", a_psdone, int'(k == 4));
      check("t1_offset", $signed(a_off), (k == 4) ? 1 : 0);
    end
    check("t1_ovf", a_ovf, 0);
    tick();
    check("t1_busy_fall", a_busy, 0);
    check("t1_done_fall", a_psdone, 0);

    // 10 increments then 12 decrements, back to back.
    do_reset();
    d0 = a_done_cnt;
    p0 = a_perr_cnt;
    for (int i = 0; i < 10; i++) req_a(1'b1);
    for (int i = 0; i < 12; i++) req_a(1'b0);
    check("t2_final_offset", $signed(a_off), -2);
    check("t2_done_count", a_done_cnt - d0, 22);
    check("t2_perr_count", a_perr_cnt - p0, 0);

    // Saturation on the PS_MAX=3 instance.
    d0 = b_done_cnt;
    for (int i = 0; i < 5; i++) begin
      req_b(1'b1);
      check("t3_sat_offset", $signed(b_off), (i < 3) ? i + 1 : 3);
      check("t3_sat_ovf", b_ovf, int'(i >= 3));
    end
    req_b(1'b0);
    check("t3_dec_offset", $signed(b_off), 2);
    check("t3_dec_ovf", b_ovf, 0);
    check("t3_done_count", b_done_cnt - d0, 6);

    // Second psen while busy: proto_err at T+3, single psdone at T+4.
    d0 = a_done_cnt;
    p0 = a_perr_cnt;
    push_a(1'b1);
    a_psen   = 1'b1;
    a_incdec = 1'b1;
    tick();
    a_psen = 1'b0;
    tick();
    a_psen   = 1'b1;
    a_incdec = 1'b0;
    tick();
    a_psen = 1'b0;
    check("t4_perr_pulse", a_perr, 1);
    tick();
    check("t4_perr_clear", a_perr, 0);
    check("t4_done", a_psdone, 1);
    tick();
    check("t4_offset", $signed(a_off), -1);
    check("t4_done_count", a_done_cnt - d0, 1);
    check("t4_perr_count", a_perr_cnt - p0, 1);

    // Requests ignored while unlocked, then a normal one.
    d0 = a_done_cnt;
    p0 = a_perr_cnt;
    a_locked = 1'b0;
    a_psen   = 1'b1;
    a_incdec = 1'b1;
    tick();
    a_psen = 1'b0;
    check("t5_unlocked_busy", a_busy, 0);
    for (int i = 0; i < 6; i++) tick();
    check("t5_unlocked_done", a_done_cnt - d0, 0);
    check("t5_unlocked_perr", a_perr_cnt - p0, 0);
    check("t5_unlocked_offset", $signed(a_off), -1);
    a_locked = 1'b1;
    req_a(1'b1);
    check("t5_locked_offset", $signed(a_off), 0);

    // Lock loss mid-operation does not abort it.
    d0 = a_done_cnt;
    push_a(1'b1);
    a_psen   = 1'b1;
    a_incdec = 1'b1;
    tick();
    a_psen   = 1'b0;
    a_locked = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t5_lockloss_done", a_done_cnt - d0, 1);
    check("t5_lockloss_offset", $signed(a_off), 1);
    a_locked = 1'b1;

    // Reset mid-operation aborts; follow-on psen at T+5 completes at T+9.
    d0 = a_done_cnt;
    a_psen   = 1'b1;
    a_incdec = 1'b1;
    tick();
    a_psen = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ma_off = 0;
    mb_off = 0;
    check("t6_rst_busy", a_busy, 0);
    check("t6_rst_offset", $signed(a_off), 0);
    check("t6_rst_done", a_psdone, 0);
    check("t6_rst_b_offset", $signed(b_off), 0);
    tick();
    tick();
    push_a(1'b1);
    a_psen   = 1'b1;
    a_incdec = 1'b1;
    tick();
    a_psen = 1'b0;
    tick();
    tick();
    check("t6_pre_done", a_psdone, 0);
    tick();
    check("t6_done_t9", a_psdone, 1);
    check("t6_done_count", a_done_cnt - d0, 1);
    tick();

    // psen coincident with rst is dropped.
    rst    = 1'b1;
    a_psen = 1'b1;
    tick();
    rst    = 1'b0;
    a_psen = 1'b0;
    ma_off = 0;
    tick();
    check("t7_rst_psen_busy", a_busy, 0);
    check("t7_rst_psen_offset", $signed(a_off), 0);

    check("a_sb_drained", sb_a.size(), 0);
    check("b_sb_drained", sb_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
